frame_stream_decoder: RTL and testbench



---
 rtl/frame_stream_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_frame_stream_decoder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_decoder.sv
`default_nettype none
//==============================================================================
// Module   : frame_stream_decoder
// Brief    : Pops 17-bit framed words from the camera FIFO, validates frame
//            geometry and emits pixels with x/y on a valid/ready interface.
// Revision : 1.0
//==============================================================================
module frame_stream_decoder #(
  parameter int FRAME_WIDTH  = 480,
  parameter int FRAME_HEIGHT = 272,
  parameter int X_BITS       = 10,
  parameter int Y_BITS       = 9
) (
  input  logic              clk,
  input  logic              reset,
  output logic              queue_rd_en,
  input  logic              queue_empty,
  input  logic [16:0]       queue_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [15:0]       pix_data,
  output logic [X_BITS-1:0] pix_x,
  output logic [Y_BITS-1:0] pix_y,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              frame_done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [15:0]       frame_count
);

  localparam logic [16:0]       c_frame_start = 17'h10000;
  localparam logic [16:0]       c_row_start   = 17'h10001;
  localparam logic [16:0]       c_frame_end   = 17'h1FFFF;
  localparam logic [X_BITS-1:0] c_x_last      = X_BITS'(FRAME_WIDTH - 1);
  localparam logic [Y_BITS-1:0] c_y_rows      = Y_BITS'(FRAME_HEIGHT);

  generate
    if (X_BITS < $clog2(FRAME_WIDTH)) begin : g_x_bits_check
      $error("X_BITS too narrow for FRAME_WIDTH");
    end
    if (Y_BITS < $clog2(FRAME_HEIGHT + 1)) begin : g_y_bits_check
      $error("Y_BITS too narrow for FRAME_HEIGHT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_WAIT_FRAME = 2'd0,
    S_WAIT_ROW   = 2'd1,
    S_PIXELS     = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0]       data;
    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
    logic              sof;
    logic              eol;
  } pix_t;

  state_t            r_state;
  logic [X_BITS-1:0] r_x;
  logic [Y_BITS-1:0] r_y;
  logic              r_rd_pending;
  logic [1:0]        r_count;
  pix_t              r_head;
  pix_t              r_tail;
  logic              r_err;
  logic [2:0]        r_err_code;
  logic              r_frame_done;
  logic [15:0]       r_frame_count;

  logic       w_is_ctrl;
  logic       w_is_fs;
  logic       w_is_rs;
  logic       w_is_fe;
  logic       w_is_bad;
  logic       w_push;
  logic       w_accept;
  logic [2:0] w_level;
  pix_t       w_new;

  assign w_is_ctrl = queue_data[16];
  assign w_is_fs   = (queue_data == c_frame_start);
  assign w_is_rs   = (queue_data == c_row_start);
  assign w_is_fe   = (queue_data == c_frame_end);
  assign w_is_bad  = w_is_ctrl && !w_is_fs && !w_is_rs && !w_is_fe;

  assign w_push   = r_rd_pending && (r_state == S_PIXELS) && !w_is_ctrl;
  assign w_new    = {queue_data[15:0], r_x, r_y,
                     (r_x == '0) && (r_y == '0), (r_x == c_x_last)};
  assign w_accept = pix_valid && pix_ready;

  // Slots still committed after this cycle; the beat leaving downstream frees one now.
  assign w_level     = 3'(r_count) + 3'(r_rd_pending) - 3'(w_accept);
  assign queue_rd_en = !reset && !queue_empty && (w_level < 3'd2);

  assign pix_valid   = (r_count != 2'd0);
  assign pix_data    = r_head.data;
  assign pix_x       = r_head.x;
  assign pix_y       = r_head.y;
  assign pix_sof     = r_head.sof;
  assign pix_eol     = r_head.eol;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_pending <= 1'b0;
    end else begin
      r_rd_pending <= queue_rd_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case ({w_push, w_accept})
        2'b10: begin
          if (r_count == 2'd0) r_head <= w_new;
          else                 r_tail <= w_new;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= w_new;
          end else begin
            r_head <= r_tail;
            r_tail <= w_new;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_WAIT_FRAME;
      r_x           <= '0;
      r_y           <= '0;
      r_err         <= 1'b0;
      r_err_code    <= 3'd0;
      r_frame_done  <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_err        <= 1'b0;
      r_frame_done <= 1'b0;
      if (r_rd_pending) begin
        if (w_is_bad && (r_state != S_WAIT_FRAME)) begin
          r_err      <= 1'b1;
          r_err_code <= 3'd6;
          r_state    <= S_WAIT_FRAME;
        end else begin
          case (r_state)
            S_WAIT_FRAME: begin
              if (w_is_fs) begin
                r_state <= S_WAIT_ROW;
                r_y     <= '0;
              end
            end
            S_WAIT_ROW: begin
              if (w_is_rs) begin
                if (r_y < c_y_rows) begin
                  r_state <= S_PIXELS;
                  r_x     <= '0;
                end else begin
                  r_err      <= 1'b1;
                  r_err_code <= 3'd4;
                  r_state    <= S_WAIT_FRAME;
                end
              end else if (w_is_fe) begin
                if (r_y == c_y_rows) begin
                  r_frame_done  <= 1'b1;
                  r_frame_count <= r_frame_count + 16'd1;
                end else begin
                  r_err      <= 1'b1;
                  r_err_code <= 3'd3;
                end
                r_state <= S_WAIT_FRAME;
              end else if (w_is_fs) begin
                r_err      <= 1'b1;
                r_err_code <= 3'd5;
                r_y        <= '0;
              end else begin
                r_err      <= 1'b1;
                r_err_code <= 3'd1;
                r_state    <= S_WAIT_FRAME;
              end
            end
            S_PIXELS: begin
              if (!w_is_ctrl) begin
                if (r_x == c_x_last) begin
                  r_y     <= r_y + Y_BITS'(1);
                  r_state <= S_WAIT_ROW;
                end else begin
                  r_x <= r_x + X_BITS'(1);
                end
              end else if (w_is_fs) begin
                r_err      <= 1'b1;
                r_err_code <= 3'd5;
                r_y        <= '0;
                r_state    <= S_WAIT_ROW;
              end else begin
                r_err      <= 1'b1;
                r_err_code <= 3'd2;
                r_state    <= S_WAIT_FRAME;
              end
            end
            default: r_state <= S_WAIT_FRAME;
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_stream_decoder.sv
`default_nettype none
//==============================================================================
// Module   : tb_frame_stream_decoder
// Brief    : Randomised FIFO/sink bench with a word-level reference parser.
// Revision : 1.0
//==============================================================================
module tb_frame_stream_decoder;

  localparam int W  = 23;
  localparam int H  = 17;
  localparam int XB = 10;
  localparam int YB = 9;
  localparam logic [16:0] FS = 17'h10000;
  localparam logic [16:0] RS = 17'h10001;
  localparam logic [16:0] FE = 17'h1FFFF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          queue_rd_en;
  logic          queue_empty = 1'b1;
  logic [16:0]   queue_data = '0;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [15:0]   pix_data;
  logic [XB-1:0] pix_x;
  logic [YB-1:0] pix_y;
  logic          pix_sof;
  logic          pix_eol;
  logic          frame_done;
  logic          err;
  logic [2:0]    err_code;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  frame_stream_decoder #(
    .FRAME_WIDTH (W),
    .FRAME_HEIGHT(H),
    .X_BITS      (XB),
    .Y_BITS      (YB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .queue_rd_en(queue_rd_en),
    .queue_empty(queue_empty),
    .queue_data (queue_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .frame_done (frame_done),
    .err        (err),
    .err_code   (err_code),
    .frame_count(frame_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    int          x;
    int          y;
    bit          sof;
    bit          eol;
  } exp_pix_t;

  exp_pix_t    exp_q[$];
  logic [16:0] fifo_q[$];

  bit          rand_ready = 1'b0;
  bit          rand_empty = 1'b0;
  int          burst_left = 0;
  bit          have_word = 1'b0;
  bit          pop_now = 1'b0;
  bit          rst_seen = 1'b0;
  logic [16:0] cur_word = '0;

  // Reference parser state: 0 idle, 1 between rows, 2 inside a row
  int m_mode = 0, m_x = 0, m_y = 0, m_count = 0, m_code = 0;
  bit m_err = 1'b0, m_done = 1'b0;

  int obs_pix = 0, obs_eol = 0, obs_sof = 0, obs_done = 0, obs_err = 0, last_code = 0;
  bit          prev_stall = 1'b0;
  logic [36:0] prev_out = '0;

  task automatic model_error(input int code);
    m_err  = 1'b1;
    m_code = code;
    if (code == 5) begin
      m_mode = 1;
      m_y    = 0;
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic model_word(input logic [16:0] w);
    bit ctrl;
    bit bad;
    ctrl = w[16];
    bad  = ctrl && (w != FS) && (w != RS) && (w != FE);
    if (m_mode == 0) begin
      if (w == FS) begin
        m_mode = 1;
        m_y    = 0;
      end
    end else if (bad) begin
      model_error(6);
    end else if (m_mode == 1) begin
      if (w == RS) begin
        if (m_y < H) begin
          m_mode = 2;
          m_x    = 0;
        end else model_error(4);
      end else if (w == FE) begin
        if (m_y == H) begin
          m_done  = 1'b1;
          m_count = (m_count + 1) % 65536;
          m_mode  = 0;
        end else model_error(3);
      end else if (w == FS) model_error(5);
      else model_error(1);
    end else begin
      if (!ctrl) begin
        exp_q.push_back('{w[15:0], m_x, m_y, (m_x == 0 && m_y == 0), (m_x == W - 1)});
        if (m_x == W - 1) begin
          m_y++;
          m_mode = 1;
        end else m_x++;
      end else if (w == FS) model_error(5);
      else model_error(2);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_x = 0; m_y = 0; m_count = 0; m_code = 0;
    m_err = 1'b0; m_done = 1'b0;
    exp_q.delete();
  endtask

  task automatic monitor();
    logic [36:0] cur;
    exp_pix_t    e;
    cur = {pix_data, pix_x, pix_y, pix_sof, pix_eol};
    check("err", 64'(err), 64'(m_err));
    check("frame_done", 64'(frame_done), 64'(m_done));
    check("err_code", 64'(err_code), 64'(m_code));
    check("frame_count", 64'(frame_count), 64'(m_count));
    check("no_empty_pop", 64'(queue_rd_en & queue_empty), 64'(0));
    if (prev_stall && !rst_seen)
      check("stall_hold", 64'({pix_valid, cur}), 64'({1'b1, prev_out}));
    if (pix_valid && pix_ready) begin
      check("pixel_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pix_data", 64'(pix_data), 64'(e.d));
        check("pix_xy", {32'(pix_x), 32'(pix_y)}, {32'(e.x), 32'(e.y)});
        check("pix_sof_eol", 64'({pix_sof, pix_eol}), 64'({e.sof, e.eol}));
      end
      obs_pix++;
      if (pix_eol) obs_eol++;
      if (pix_sof) obs_sof++;
    end
    if (frame_done) obs_done++;
    if (err) begin
      obs_err++;
      last_code = int'(err_code);
    end
    prev_stall = pix_valid && !pix_ready;
    prev_out   = cur;
  endtask

  // FIFO model, downstream sink and reference model stepping
  initial begin
    forever begin
      @(negedge clk);
      monitor();
      pop_now = queue_rd_en && !queue_empty;
      @(posedge clk);
      rst_seen = reset;
      m_err    = 1'b0;
      m_done   = 1'b0;
      if (rst_seen) model_reset();
      else if (have_word) model_word(cur_word);
      if (rst_seen) pop_now = 1'b0;
      have_word = pop_now;
      #1;
      if (pop_now && fifo_q.size() > 0) begin
        cur_word   = fifo_q.pop_front();
        queue_data = cur_word;
      end
      pix_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (!rand_empty) burst_left = 0;
      else if (burst_left > 0) burst_left--;
      else if ($urandom_range(0, 9) == 0) burst_left = $urandom_range(1, 6);
      queue_empty = (fifo_q.size() == 0) || (burst_left > 0);
    end
  end

  task automatic push_row(input int n);
    fifo_q.push_back(RS);
    for (int i = 0; i < n; i++) fifo_q.push_back({1'b0, 16'($urandom)});
  endtask

  task automatic push_rows(input int rows);
    for (int r = 0; r < rows; r++) push_row(W);
  endtask

  task automatic push_frame();
    fifo_q.push_back(FS);
    push_rows(H);
    fifo_q.push_back(FE);
  endtask

  task automatic clear_obs();
    obs_pix = 0; obs_eol = 0; obs_sof = 0; obs_done = 0; obs_err = 0;
  endtask

  task automatic wait_idle();
    bit done_ok;
    done_ok = 1'b0;
    for (int i = 0; i < 20000 && !done_ok; i++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && !have_word && exp_q.size() == 0 && !pix_valid && !queue_rd_en)
        done_ok = 1'b1;
    end
    repeat (4) @(negedge clk);
    check("idle_reached", 64'(done_ok), 64'(1));
  endtask

  task automatic check_zero(input string tag);
    check(tag, 64'({pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, frame_done,
                    err, err_code, frame_count, queue_rd_en}), 64'(0));
  endtask

  initial begin
    bit got_pix;
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    @(posedge clk); #2 reset = 1'b0;

    // Clean frame, sink always ready
    clear_obs(); push_frame(); wait_idle();
    check("s1_pixels", 64'(obs_pix), 64'(W * H));
    check("s1_eol", 64'(obs_eol), 64'(H));
    check("s1_sof", 64'(obs_sof), 64'(1));
    check("s1_done", 64'(obs_done), 64'(1));
    check("s1_errs", 64'(obs_err), 64'(0));
    check("s1_count", 64'(frame_count), 64'(1));

    rand_ready = 1'b1;
    rand_empty = 1'b1;
    clear_obs(); push_frame(); wait_idle();
    check("s2_pixels", 64'(obs_pix), 64'(W * H));
    check("s2_done", 64'(obs_done), 64'(1));
    check("s2_errs", 64'(obs_err), 64'(0));
    check("s2_count", 64'(frame_count), 64'(2));

    // Short row
    clear_obs(); fifo_q.push_back(FS); push_row(20); push_row(W); wait_idle();
    check("s3_err", 64'(obs_err), 64'(1));
    check("s3_code", 64'(last_code), 64'(2));
    check("s3_pixels", 64'(obs_pix), 64'(20));
    clear_obs(); push_frame(); wait_idle();
    check("s3_recover_done", 64'(obs_done), 64'(1));
    check("s3_recover_count", 64'(frame_count), 64'(3));

    // Too few rows
    clear_obs(); fifo_q.push_back(FS); push_rows(H - 1); fifo_q.push_back(FE); wait_idle();
    check("s4_err", 64'(obs_err), 64'(1));
    check("s4_code", 64'(last_code), 64'(3));
    check("s4_done", 64'(obs_done), 64'(0));

    // Restart mid-row 5
    clear_obs(); fifo_q.push_back(FS); push_rows(5); push_row(7); push_frame(); wait_idle();
    check("s5_err", 64'(obs_err), 64'(1));
    check("s5_code", 64'(last_code), 64'(5));
    check("s5_done", 64'(obs_done), 64'(1));
    check("s5_pixels", 64'(obs_pix), 64'(5 * W + 7 + W * H));
    check("s5_count", 64'(frame_count), 64'(4));

    // Bad control word
    clear_obs(); fifo_q.push_back(FS); push_rows(2); push_row(4);
    fifo_q.push_back(17'h10002); push_row(5); wait_idle();
    check("s6_err", 64'(obs_err), 64'(1));
    check("s6_code", 64'(last_code), 64'(6));
    check("s6_pixels", 64'(obs_pix), 64'(2 * W + 4));

    // Pixel outside a row, then an extra row
    clear_obs(); fifo_q.push_back(FS); fifo_q.push_back(17'h01234); wait_idle();
    check("s8_code1", 64'(last_code), 64'(1));
    fifo_q.push_back(FS); push_rows(H); fifo_q.push_back(RS); wait_idle();
    check("s8_errs", 64'(obs_err), 64'(2));
    check("s8_code4", 64'(last_code), 64'(4));
    check("s8_done", 64'(obs_done), 64'(0));

    // Reset mid-row
    clear_obs(); push_frame();
    got_pix = 1'b0;
    for (int i = 0; i < 5000 && !got_pix; i++) begin
      @(negedge clk);
      if (obs_pix >= 50) got_pix = 1'b1;
    end
    check("s7_reached_midrow", 64'(got_pix), 64'(1));
    @(posedge clk); #2 reset = 1'b1; fifo_q.delete();
    @(posedge clk); @(negedge clk);
    check_zero("s7_reset_outputs");
    @(posedge clk); #2 reset = 1'b0;
    clear_obs(); push_frame(); wait_idle();
    check("s7_pixels", 64'(obs_pix), 64'(W * H));
    check("s7_done", 64'(obs_done), 64'(1));
    check("s7_count", 64'(frame_count), 64'(1));
    check("s7_errs", 64'(obs_err), 64'(0));

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
